// File: rtl/mem_read_responder.sv
// mem_read_responder
//   Pipelined single-port word memory answering cache fill reads and
//   write-through stores. One request is accepted on every rising edge that
//   enable_i is high; there is no backpressure. Reads sample the array at
//   accept and return through a LATENCY-deep {valid, data} pipeline, so the
//   strobe appears exactly LATENCY cycles after the request cycle and
//   responses come back strictly in request order.
//
// Handshake: a request is a one-cycle pulse of enable_i qualified by wr_i,
//   always taken on the next rising edge. A response is a one-cycle
//   data_valid_o pulse, with data_out_o carrying the word only in that cycle
//   (zero otherwise). The consumer cannot stall the responder.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset (clears in-flight reads)
//   enable_i     request present this cycle
//   wr_i         1 = write, 0 = read (qualified by enable_i)
//   addr_i       byte address; word index = addr_i[DEPTH_W:1]
//   data_in_i    write data
//   data_out_o   read data, zero when data_valid_o is low
//   data_valid_o one-cycle read-return strobe
//   busy_o       at least one read accepted and not yet returned
module mem_read_responder #(
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        wr_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_in_i,
  output logic [15:0] data_out_o,
  output logic        data_valid_o,
  output logic        busy_o
);

  localparam int WORDS = 1 << DEPTH_W;

  logic [15:0]        mem_q [WORDS];
  logic [DEPTH_W-1:0] idx;
  logic               rd_accept;
  logic               wr_accept;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [15:0]        dat_q [LATENCY];
  logic [15:0]        dat_d [LATENCY];

  // Byte-offset bit and address bits above the array alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[15:DEPTH_W+1], addr_i[0]};

  assign idx       = addr_i[DEPTH_W:1];
  assign rd_accept = enable_i & ~wr_i;
  assign wr_accept = enable_i &  wr_i;

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[idx] <= data_in_i;
    end
  end

  // Stage 0 captures the addressed word at accept, so a later write to the
  // same word cannot change a read already in flight. Later stages shift.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_accept;
    dat_d[0] = mem_q[idx];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Data stages need no reset: they are only observed through vld_q.
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  // Outputs come straight from registers, so there is no combinational
  // path from addr_i to data_out_o at any latency.
  assign data_valid_o = vld_q[LATENCY-1];
  assign data_out_o   = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : 16'h0000;
  assign busy_o       = |vld_q;

endmodule

// File: tb/tb_mem_read_responder.sv
module tb_mem_read_responder;

  localparam int DEPTH_W = 10;
  localparam int LAT     = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;

  mem_read_responder #(.DEPTH_W(DEPTH_W), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .wr_i        (wr),
    .addr_i      (addr),
    .data_in_i   (data_in),
    .data_out_o  (data_out),
    .data_valid_o(data_valid),
    .busy_o      (busy)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Outstanding reads: expected word, request cycle, return cycle.
  logic [15:0] exp_q[$];
  int          issue_q[$];
  int          due_q[$];

  // Model memory indexed by word index.
  logic [15:0] model_mem [int];

  // Strobes observed by the compare process, for literal checks.
  int          obs_cyc_q[$];
  logic [15:0] obs_dat_q[$];

  int last_issue;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_idle();
    @(posedge clk); #1;
    enable = 1'b0; wr = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    enable = 1'b1; wr = 1'b1; addr = a; data_in = d;
    model_mem[int'(a[DEPTH_W:1])] = d;
  endtask

  task automatic do_read(input logic [15:0] a);
    @(posedge clk); #1;
    enable = 1'b1; wr = 1'b0; addr = a;
    data_in = 16'($urandom_range(0, 65535));
    exp_q.push_back(model_mem[int'(a[DEPTH_W:1])]);
    issue_q.push_back(cyc);
    due_q.push_back(cyc + LAT);
    last_issue = cyc;
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; wr = 1'b0;
    exp_q.delete(); issue_q.delete(); due_q.delete();
    #1;
    check("busy_on_reset", 32'(busy), 32'd0);
    check("valid_on_reset", 32'(data_valid), 32'd0);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs_cyc_q.delete();
    obs_dat_q.delete();
  endtask

  task automatic check_obs(input int i, input int exp_cyc, input logic [15:0] exp_d);
    if (i < obs_cyc_q.size()) begin
      check("strobe_cycle", 32'(obs_cyc_q[i]), 32'(exp_cyc));
      check("strobe_data", 32'(obs_dat_q[i]), 32'(exp_d));
    end else begin
      check("strobe_present", 32'd0, 32'd1);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_b;
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    exp_d = exp_v ? exp_q[0] : 16'h0000;
    exp_b = 1'b0;
    foreach (issue_q[i]) if (issue_q[i] < cyc) exp_b = 1'b1;
    check("data_valid", 32'(data_valid), 32'(exp_v));
    check("data_out", 32'(data_out), 32'(exp_d));
    check("busy", 32'(busy), 32'(exp_b));
    if (data_valid) begin
      obs_cyc_q.push_back(cyc);
      obs_dat_q.push_back(data_out);
    end
    if (exp_v) begin
      void'(exp_q.pop_front());
      void'(issue_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int n2;
    rst_n = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: nothing may come out.
    clear_obs();
    repeat (10) do_idle();
    check("idle_strobe_count", 32'(obs_cyc_q.size()), 32'd0);

    // Write then read back-to-back.
    clear_obs();
    do_write(16'h0010, 16'hBEEF);
    do_read(16'h0010);
    n = last_issue;
    repeat (8) do_idle();
    check("raw_strobe_count", 32'(obs_cyc_q.size()), 32'd1);
    check_obs(0, n + 4, 16'hBEEF);

    // Cache-line fill: 8 back-to-back reads.
    for (int k = 0; k < 8; k++) do_write(16'h0100 + 16'(2 * k), 16'h1000 + 16'(k));
    do_idle();
    clear_obs();
    for (int k = 0; k < 8; k++) begin
      do_read(16'h0100 + 16'(2 * k));
      if (k == 0) n = last_issue;
    end
    repeat (10) do_idle();
    check("fill_strobe_count", 32'(obs_cyc_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) check_obs(k, n + 4 + k, 16'h1000 + 16'(k));

    // Write after read must not disturb the in-flight read.
    do_write(16'h0020, 16'h1111);
    clear_obs();
    do_read(16'h0020);
    n = last_issue;
    do_write(16'h0020, 16'h2222);
    do_idle();
    do_read(16'h0020);
    n2 = last_issue;
    repeat (8) do_idle();
    check("war_strobe_count", 32'(obs_cyc_q.size()), 32'd2);
    check_obs(0, n + 4, 16'h1111);
    check_obs(1, n2 + 4, 16'h2222);

    // Reset with reads in flight: they must vanish.
    clear_obs();
    do_read(16'h0010);
    do_read(16'h0100);
    do_read(16'h0020);
    do_reset(2);
    repeat (10) do_idle();
    check("reset_strobe_count", 32'(obs_cyc_q.size()), 32'd0);

    // Bubble pattern R,-,R,R,-,R; 0x0011 aliases 0x0010.
    clear_obs();
    do_read(16'h0011);
    n = last_issue;
    do_idle();
    do_read(16'h0102);
    do_read(16'h010E);
    do_idle();
    do_read(16'hF810);
    repeat (8) do_idle();
    check("bubble_strobe_count", 32'(obs_cyc_q.size()), 32'd4);
    check_obs(0, n + 4, 16'hBEEF);
    check_obs(1, n + 6, 16'h1001);
    check_obs(2, n + 7, 16'h1007);
    check_obs(3, n + 9, 16'hBEEF);

    repeat (3) do_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
